// File: rtl/console_pkg.sv
// Shared geometry, control codes and FSM encoding for the text console.
// console_driver reuses COLS/ROWS and console_addr for its read path.
package console_pkg;

  localparam int unsigned COLS  = 80;
  localparam int unsigned ROWS  = 30;
  localparam int unsigned CELLS = COLS * ROWS;

  localparam int unsigned AW = 13;  // char RAM address width
  localparam int unsigned CW = 7;   // column width
  localparam int unsigned RW = 5;   // row width
  localparam int unsigned NW = 12;  // clear counter width, holds CELLS-1

  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_CLEAR_ROW = 2'd1;
  localparam logic [1:0] ST_CLEAR_ALL = 2'd2;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/console_addr.sv
// Maps a logical (topRow, row, col) to a char RAM address, wrapping the
// physical row modulo ROWS so scrolling is a pure topRow rotation.
module console_addr
  import console_pkg::*;
(
  input  logic [RW-1:0] top_i,
  input  logic [RW-1:0] row_i,
  input  logic [CW-1:0] col_i,
  output logic [AW-1:0] addr_o
);

  localparam logic [RW:0] RowsW = RW'(ROWS);

  logic [RW:0]   sum;
  logic [RW:0]   diff;
  logic [RW-1:0] phys;

  always_comb begin
    sum  = {1'b0, top_i} + {1'b0, row_i};
    diff = sum - RowsW;
    phys = (sum >= RowsW) ? diff[RW-1:0] : sum[RW-1:0];
    addr_o = AW'(phys) * AW'(COLS) + AW'(col_i);
  end

endmodule

// File: rtl/console_writer.sv
// Text-mode writer: decodes a host byte stream into char RAM writes, tracks
// the cursor and scrolls by rotating topRow with a bottom-row clear.
module console_writer
  import console_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    inData,
  input  logic          inValid,
  output logic          inReady,
  output logic [AW-1:0] addrWChar,
  output logic [7:0]    dataWChar,
  output logic          weChar,
  output logic [CW-1:0] cursorCol,
  output logic [RW-1:0] cursorRow,
  output logic [RW-1:0] topRow,
  output logic          busy
);

  logic [1:0]    state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] top_q, top_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    data_q, data_d;

  logic          accept;
  logic          newline;
  logic [RW-1:0] a_row;
  logic [CW-1:0] a_col;
  logic [AW-1:0] cell_addr;

  assign accept = inValid && (state_q == ST_IDLE);

  // CLEAR_ROW runs after topRow has advanced, so ROWS-1 is the new bottom row.
  always_comb begin
    a_row = row_q;
    a_col = col_q;
    if (state_q == ST_CLEAR_ROW) begin
      a_row = RW'(ROWS - 1);
      a_col = cnt_q[CW-1:0];
    end else if (inData == CH_BS) begin
      a_col = col_q - 1'b1;
    end
  end

  console_addr u_addr (
    .top_i  (top_q),
    .row_i  (a_row),
    .col_i  (a_col),
    .addr_o (cell_addr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    top_d   = top_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    newline = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_printable(inData)) begin
            we_d   = 1'b1;
            data_d = inData;
            addr_d = cell_addr;
            if (col_q == CW'(COLS - 1)) begin
              col_d   = '0;
              newline = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            case (inData)
              CH_CR: col_d = '0;
              CH_LF: begin
                col_d   = '0;
                newline = 1'b1;
              end
              CH_BS: begin
                if (col_q != '0) begin
                  col_d  = col_q - 1'b1;
                  we_d   = 1'b1;
                  data_d = BLANK;
                  addr_d = cell_addr;
                end
              end
              CH_FF: begin
                state_d = ST_CLEAR_ALL;
                cnt_d   = '0;
                col_d   = '0;
                row_d   = '0;
                top_d   = '0;
              end
              default: ;
            endcase
          end

          if (newline) begin
            if (row_q != RW'(ROWS - 1)) begin
              row_d = row_q + 1'b1;
            end else begin
              top_d   = (top_q == RW'(ROWS - 1)) ? '0 : top_q + 1'b1;
              state_d = ST_CLEAR_ROW;
              cnt_d   = '0;
            end
          end
        end
      end

      ST_CLEAR_ROW: begin
        we_d   = 1'b1;
        data_d = BLANK;
        addr_d = cell_addr;
        if (cnt_q == NW'(COLS - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_CLEAR_ALL: begin
        we_d   = 1'b1;
        data_d = BLANK;
        addr_d = AW'(cnt_q);
        if (cnt_q == NW'(CELLS - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_CLEAR_ALL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR_ALL;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      top_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      top_q   <= top_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign inReady   = (state_q == ST_IDLE);
  assign busy      = ~inReady;
  assign weChar    = we_q;
  assign addrWChar = addr_q;
  assign dataWChar = data_q;
  assign cursorCol = col_q;
  assign cursorRow = row_q;
  assign topRow    = top_q;

endmodule
